// File: rtl/ifft4_stream.sv
// ifft4_stream: streaming 4-point inverse DFT over complex 4-bit signed bins.
// Two registered stages (butterfly sums, then twiddle/scale/saturate) with
// valid/ready handshakes on both sides. Output is scaled by 1/4 and clamped
// to the 4-bit signed range; out_sat flags any clipped component.
module ifft4_stream #(
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat
);

    // Sign-extend a 4-bit two's complement nibble to 5 bits.
    function automatic logic signed [4:0] sext5(input logic [3:0] n);
        return {n[3], n};
    endfunction

    // Sign-extend a 5-bit stage-1 value to 6 bits.
    function automatic logic signed [5:0] sext6(input logic signed [4:0] n);
        return {n[4], n};
    endfunction

    // Divide a 6-bit value by 4 (rounded or floored) in 7 bits so the
    // rounding offset cannot wrap, then clamp to [-8, 7].
    // Result is {clip_flag, nibble}.
    function automatic logic [4:0] scale_sat(input logic signed [5:0] v);
        logic signed [6:0] w;
        logic signed [6:0] q;
        logic [4:0]        res;
        w = {v[5], v} + ((ROUND != 0) ? 7'sd2 : 7'sd0);
        q = w >>> 2;
        if (q > 7'sd7) begin
            res = {1'b1, 4'd7};
        end else if (q < -7'sd8) begin
            res = {1'b1, 4'd8};
        end else begin
            res = {1'b0, q[3:0]};
        end
        return res;
    endfunction

    // Pipeline control.
    logic s1_v_r;
    logic s2_load_s;
    logic s1_load_s;

    // Stage-1 butterfly registers.
    logic signed [4:0] a_re_r, a_im_r, b_re_r, b_im_r;
    logic signed [4:0] c_re_r, c_im_r, d_re_r, d_im_r;

    // Stage-1 combinational butterflies.
    logic signed [4:0] a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [4:0] c_re_s, c_im_s, d_re_s, d_im_s;

    // Stage-2 combinational results.
    logic signed [5:0] x0_re_s, x0_im_s, x1_re_s, x1_im_s;
    logic signed [5:0] x2_re_s, x2_im_s, x3_re_s, x3_im_s;
    logic [4:0]        q0r_s, q0i_s, q1r_s, q1i_s, q2r_s, q2i_s, q3r_s, q3i_s;
    logic [31:0]       nxt_data_s;
    logic              nxt_sat_s;

    // S2 can take a new value when it is empty or being drained; S1 then
    // advances whenever it is empty or S2 absorbs it. No path from in_valid.
    assign s2_load_s = !out_valid || out_ready;
    assign s1_load_s = !s1_v_r || s2_load_s;
    assign in_ready  = s1_load_s;

    // First butterfly layer: pair bins 0/2 and 1/3.
    always_comb begin
        a_re_s = sext5(in_data[31:28]) + sext5(in_data[15:12]);
        a_im_s = sext5(in_data[27:24]) + sext5(in_data[11:8]);
        b_re_s = sext5(in_data[31:28]) - sext5(in_data[15:12]);
        b_im_s = sext5(in_data[27:24]) - sext5(in_data[11:8]);
        c_re_s = sext5(in_data[23:20]) + sext5(in_data[7:4]);
        c_im_s = sext5(in_data[19:16]) + sext5(in_data[3:0]);
        d_re_s = sext5(in_data[23:20]) - sext5(in_data[7:4]);
        d_im_s = sext5(in_data[19:16]) - sext5(in_data[3:0]);
    end

    // Stage-1 register: valid bit and butterfly values, captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r <= 1'b0;
            a_re_r <= 5'sd0;
            a_im_r <= 5'sd0;
            b_re_r <= 5'sd0;
            b_im_r <= 5'sd0;
            c_re_r <= 5'sd0;
            c_im_r <= 5'sd0;
            d_re_r <= 5'sd0;
            d_im_r <= 5'sd0;
        end else if (s1_load_s) begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                a_re_r <= a_re_s;
                a_im_r <= a_im_s;
                b_re_r <= b_re_s;
                b_im_r <= b_im_s;
                c_re_r <= c_re_s;
                c_im_r <= c_im_s;
                d_re_r <= d_re_s;
                d_im_r <= d_im_s;
            end
        end
    end

    // Second butterfly layer with the +j/-j twiddle on the odd outputs,
    // followed by scaling, clamping and packing.
    always_comb begin
        x0_re_s = sext6(a_re_r) + sext6(c_re_r);
        x0_im_s = sext6(a_im_r) + sext6(c_im_r);
        x2_re_s = sext6(a_re_r) - sext6(c_re_r);
        x2_im_s = sext6(a_im_r) - sext6(c_im_r);
        x1_re_s = sext6(b_re_r) - sext6(d_im_r);
        x1_im_s = sext6(b_im_r) + sext6(d_re_r);
        x3_re_s = sext6(b_re_r) + sext6(d_im_r);
        x3_im_s = sext6(b_im_r) - sext6(d_re_r);

        q0r_s = scale_sat(x0_re_s);
        q0i_s = scale_sat(x0_im_s);
        q1r_s = scale_sat(x1_re_s);
        q1i_s = scale_sat(x1_im_s);
        q2r_s = scale_sat(x2_re_s);
        q2i_s = scale_sat(x2_im_s);
        q3r_s = scale_sat(x3_re_s);
        q3i_s = scale_sat(x3_im_s);

        nxt_data_s = {q0r_s[3:0], q0i_s[3:0], q1r_s[3:0], q1i_s[3:0],
                      q2r_s[3:0], q2i_s[3:0], q3r_s[3:0], q3i_s[3:0]};
        nxt_sat_s  = q0r_s[4] | q0i_s[4] | q1r_s[4] | q1i_s[4] |
                     q2r_s[4] | q2i_s[4] | q3r_s[4] | q3i_s[4];
    end

    // Stage-2 output register: holds result stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_sat   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_v_r;
            if (s1_v_r) begin
                out_data <= nxt_data_s;
                out_sat  <= nxt_sat_s;
            end
        end
    end

endmodule

// File: tb/tb_ifft4_stream.sv
// Testbench for ifft4_stream: directed test-plan vectors, backpressure,
// full-rate streaming, randomized handshakes and async reset mid-stream,
// checked against a direct inverse-DFT reference model and a FIFO scoreboard.
module tb_ifft4_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;

    int          n_assert;
    int          n_fail;
    logic [32:0] exp_q[$];

    ifft4_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divide by 4 with round-half-up, then clamp to the 4-bit signed range.
    function automatic int tb_scale(input int s, output bit clip);
        int q;
        q = (s + 2) >>> 2;
        clip = 1'b0;
        if (q > 7) begin
            q = 7;
            clip = 1'b1;
        end
        if (q < -8) begin
            q = -8;
            clip = 1'b1;
        end
        return q;
    endfunction

    // Reference: x[n] = sum_k X[k] * j^(n*k), scaled by 1/4. Returns {sat, data}.
    function automatic logic [32:0] ref_ifft(input logic [31:0] v);
        int          xr[4];
        int          xi[4];
        int          sr, si, qr, qi;
        bit          cr, ci;
        logic [3:0]  nr, ni;
        logic [32:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            xr[k] = int'(v[31-8*k -: 4]);
            xi[k] = int'(v[27-8*k -: 4]);
            if (xr[k] > 7) xr[k] = xr[k] - 16;
            if (xi[k] > 7) xi[k] = xi[k] - 16;
        end
        for (int n = 0; n < 4; n++) begin
            sr = 0;
            si = 0;
            for (int k = 0; k < 4; k++) begin
                case ((n * k) % 4)
                    0: begin sr = sr + xr[k]; si = si + xi[k]; end
                    1: begin sr = sr - xi[k]; si = si + xr[k]; end
                    2: begin sr = sr - xr[k]; si = si - xi[k]; end
                    default: begin sr = sr + xi[k]; si = si - xr[k]; end
                endcase
            end
            qr = tb_scale(sr, cr);
            qi = tb_scale(si, ci);
            nr = qr[3:0];
            ni = qi[3:0];
            r[31-8*n -: 4] = nr;
            r[27-8*n -: 4] = ni;
            r[32] = r[32] | cr | ci;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample both handshakes just before the edge, score a pop against the
    // oldest expected vector, queue an accept, then advance one clock.
    task automatic tick(output bit acc);
        bit pop;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (pop) begin
            check("pop_expected", {32'b0, exp_q.size() > 0}, 33'd1);
            if (exp_q.size() > 0) begin
                check("out_vector", {out_sat, out_data}, exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(ref_ifft(in_data));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] v, input logic [32:0] exp);
        bit acc;
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        tick(acc);
        check({tag, "_accept"}, {32'b0, acc}, 33'd1);
        in_valid = 1'b0;
        check({tag, "_lat0"}, {32'b0, out_valid}, 33'd0);
        tick(acc);
        check({tag, "_lat1"}, {32'b0, out_valid}, 33'd1);
        check({tag, "_data"}, {out_sat, out_data}, exp);
        tick(acc);
        check({tag, "_done"}, {32'b0, out_valid}, 33'd0);
    endtask

    initial begin
        bit acc;
        logic [31:0] vec[4];
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_out_valid", {32'b0, out_valid}, 33'd0);
        check("rst_out", {out_sat, out_data}, 33'd0);
        check("rst_in_ready", {32'b0, in_ready}, 33'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Test-plan vectors (first one accepted on first edge after release).
        directed("impulse", 32'h40000000, {1'b0, 32'h10101010});
        directed("const",   32'h40404040, {1'b0, 32'h40000000});
        directed("bin1",    32'h00400000, {1'b0, 32'h1001F00F});
        directed("sat",     32'h70088007, {1'b1, 32'h00700000});

        // Backpressure: four back-to-back vectors, out_ready low for 3 cycles.
        for (int i = 0; i < 4; i++) vec[i] = $urandom();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vec[0];
        tick(acc);
        check("bp_acc0", {32'b0, acc}, 33'd1);
        in_data = vec[1];
        tick(acc);
        check("bp_acc1", {32'b0, acc}, 33'd1);
        in_data = vec[2];
        tick(acc);
        check("bp_full_block", {32'b0, acc}, 33'd0);
        check("bp_in_ready_low", {32'b0, in_ready}, 33'd0);
        check("bp_hold_valid", {32'b0, out_valid}, 33'd1);
        check("bp_hold_data", {out_sat, out_data}, ref_ifft(vec[0]));
        out_ready = 1'b1;
        tick(acc);
        check("bp_resume_acc2", {32'b0, acc}, 33'd1);
        in_data = vec[3];
        tick(acc);
        check("bp_resume_acc3", {32'b0, acc}, 33'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);
        check("bp_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

        // Full-rate streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            tick(acc);
            check("tput_accept", {32'b0, acc}, 33'd1);
            if (i >= 1) check("tput_out_valid", {32'b0, out_valid}, 33'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);
        check("tput_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

        // Randomized handshakes on both sides; input held until accepted.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = $urandom();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(acc);
        check("rand_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

        // Async reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom();
        tick(acc);
        in_data = $urandom();
        tick(acc);
        in_valid = 1'b0;
        check("mid_full", {32'b0, out_valid}, 33'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {32'b0, out_valid}, 33'd0);
        check("mid_rst_out", {out_sat, out_data}, 33'd0);
        check("mid_rst_in_ready", {32'b0, in_ready}, 33'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("post_rst_idle", {32'b0, out_valid}, 33'd0);
        end
        directed("post_rst", 32'h40000000, {1'b0, 32'h10101010});
        check("post_rst_drained", {1'b0, 32'(exp_q.size())}, 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
